stage_if: RTL and testbench

//  Instruction-fetch stage of the 5-stage MIPS pipeline; feeds stage_id (instr, pc_id, nop_if).

---
 rtl/stage_if_pkg.sv | 21 ++
 rtl/stage_if_pc_unit.sv | 26 ++
 rtl/stage_if.sv | 128 ++++++++++++
 tb/tb_stage_if.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_if_pkg.sv
// Shared definitions for the instruction-fetch stage: default constants,
// FSM state encodings, opcode field range and HALT decode helper.
package stage_if_pkg;

    localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR   = 32'h0000_0000;
    localparam logic [5:0]  DEF_HALT_OPCODE = 6'b111111;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    function automatic logic is_halt(input logic [31:0] word, input logic [5:0] opcode);
        return word[OPCODE_HI:OPCODE_LO] == opcode;
    endfunction

endpackage

// File: rtl/stage_if_pc_unit.sv
// Program counter for the fetch stage: holds, advances by one word, or
// loads a word-aligned redirect target.
module stage_if_pc_unit
    import stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        inc,
    input  logic [31:0] jump_addr,
    output logic [31:0] pc
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc <= RESET_PC & 32'hFFFF_FFFC;
        end else if (load) begin
            pc <= jump_addr & 32'hFFFF_FFFC;
        end else if (inc) begin
            pc <= pc + 32'd4;
        end
    end

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: request/grant/valid memory port with variable
// latency, 1-entry skid buffer for stalls, redirect with stale-response drop.
module stage_if
    import stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR   = DEF_NOP_INSTR,
    parameter logic [5:0]  HALT_OPCODE = DEF_HALT_OPCODE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        isJumped,
    input  logic [31:0] jumpAddr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc_id,
    output logic        nop_if,
    output logic        halted,
    output logic [31:0] fetchCount
);

    logic [1:0]  state;
    logic        drop;
    logic        skid_full;
    logic [31:0] skid_data;
    logic [31:0] skid_pc;
    logic [31:0] pc;
    logic [31:0] pc_seq;
    logic        granted;
    logic        resp;
    logic        resp_halt;
    logic        resp_ok;

    // A response only counts in WAIT; a dropped one belongs to a flushed path.
    assign resp      = imem_valid && !drop && (state == ST_WAIT);
    assign resp_halt = resp && is_halt(imem_rdata, HALT_OPCODE);
    assign resp_ok   = resp && !resp_halt;

    // Requests wait for a pending stale response and for the skid to drain,
    // so at most one response is ever outstanding.
    assign imem_req  = (state == ST_REQ) && !drop && !skid_full;
    assign granted   = imem_req && imem_gnt;
    assign imem_addr = pc;
    assign pc_seq    = pc + 32'd4;

    stage_if_pc_unit #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock     (clock),
        .reset     (reset),
        .load      (isJumped),
        .inc       (resp_ok),
        .jump_addr (jumpAddr),
        .pc        (pc)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            drop       <= 1'b0;
            skid_full  <= 1'b0;
            halted     <= 1'b0;
            fetchCount <= 32'd0;
            instr      <= NOP_INSTR;
            pc_id      <= 32'd0;
            nop_if     <= 1'b1;
        end else if (isJumped) begin
            state     <= ST_REQ;
            // Keep discarding if the stale word has not arrived yet, or start
            // discarding if the current fetch is already granted.
            drop      <= (drop && !imem_valid) ||
                         ((state == ST_WAIT) && !imem_valid) || granted;
            skid_full <= 1'b0;
            halted    <= 1'b0;
            instr     <= NOP_INSTR;
            nop_if    <= 1'b1;
        end else begin
            if (drop && imem_valid) begin
                drop <= 1'b0;
            end
            case (state)
                ST_IDLE: state <= ST_REQ;
                ST_REQ:  if (granted) state <= ST_WAIT;
                ST_WAIT: begin
                    if (resp_halt) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else if (resp_ok) begin
                        state <= ST_REQ;
                    end
                end
                default: ;
            endcase
            if (!stall) begin
                if (skid_full) begin
                    instr      <= skid_data;
                    pc_id      <= skid_pc;
                    nop_if     <= 1'b0;
                    fetchCount <= fetchCount + 32'd1;
                    skid_full  <= 1'b0;
                end else if (resp_ok) begin
                    instr      <= imem_rdata;
                    pc_id      <= pc_seq;
                    nop_if     <= 1'b0;
                    fetchCount <= fetchCount + 32'd1;
                end else begin
                    instr  <= NOP_INSTR;
                    nop_if <= 1'b1;
                end
            end else if (resp_ok) begin
                skid_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (resp_ok && stall) begin
            skid_data <= imem_rdata;
            skid_pc   <= pc_seq;
        end
    end

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: random-latency memory model, path-level expected
// instruction stream in a scoreboard queue, and an independent monitor.
module tb_stage_if;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        isJumped;
    logic [31:0] jumpAddr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc_id;
    logic        nop_if;
    logic        halted;
    logic [31:0] fetchCount;

    always #5 clock = ~clock;

    stage_if dut (
        .clock      (clock),
        .reset      (reset),
        .stall      (stall),
        .isJumped   (isJumped),
        .jumpAddr   (jumpAddr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .pc_id      (pc_id),
        .nop_if     (nop_if),
        .halted     (halted),
        .fetchCount (fetchCount)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc_id;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] ovr [logic [31:0]];
    logic [31:0] halt_addr = 32'hFFFF_FFF0;
    int          total = 0;
    int          bad = 0;
    int          gnt_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    int          stall_pct = 0;
    bit          stall_force = 1'b0;
    bit          mem_busy = 1'b0;

    // Program image: one HALT word at halt_addr, a few fixed words, else a hash.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == halt_addr) return 32'hFC00_0000 | {6'd0, a[25:0]};
        if (ovr.exists(a)) return ovr[a];
        return {6'h08, a[25:0] ^ 26'h15A_5A5};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
        end
    endtask

    // Memory: grant randomly, answer each grant once after lat_min..lat_max cycles.
    initial begin
        int          cnt;
        logic [31:0] addr;
        cnt = 0;
        addr = 32'd0;
        imem_gnt = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = 32'd0;
        forever begin
            @(negedge clock);
            imem_valid = 1'b0;
            if (mem_busy) begin
                cnt--;
                if (cnt <= 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem_word(addr);
                    mem_busy = 1'b0;
                end
            end
            imem_gnt = (int'($urandom_range(99, 0)) < gnt_pct);
            #4;
            if (!reset) begin
                mem_busy = 1'b0;
            end else if (imem_req && imem_gnt) begin
                mem_busy = 1'b1;
                addr = imem_addr;
                cnt = int'($urandom_range(lat_max, lat_min));
            end
        end
    end

    // Monitor: classify each edge by the inputs seen just before it.
    initial begin
        bit          ps, pj, pr;
        logic [31:0] li, lp;
        logic        ln;
        int          deliveries;
        exp_t        e;
        deliveries = 0;
        forever begin
            @(negedge clock);
            #4;
            ps = stall; pj = isJumped; pr = reset;
            li = instr; lp = pc_id; ln = nop_if;
            @(posedge clock);
            #1;
            if (!pr) begin
                deliveries = 0;
                check("rst_instr", instr, 32'h0);
                check("rst_pc_id", pc_id, 32'h0);
                check("rst_nop_if", 32'(nop_if), 1);
                check("rst_halted", 32'(halted), 0);
                check("rst_req", 32'(imem_req), 0);
                check("rst_count", fetchCount, 0);
            end else if (pj) begin
                check("jump_bubble", 32'(nop_if), 1);
            end else if (ps) begin
                check("stall_hold_instr", instr, li);
                check("stall_hold_pc_id", pc_id, lp);
                check("stall_hold_nop", 32'(nop_if), 32'(ln));
            end else if (!nop_if) begin
                deliveries++;
                check("deliv_count", fetchCount, 32'(deliveries));
                if (sbq.size() == 0) begin
                    check("unexpected_delivery", pc_id, 32'hDEAD_BEEF);
                end else begin
                    e = sbq.pop_front();
                    check("deliv_instr", instr, e.instr);
                    check("deliv_pc_id", pc_id, e.pc_id);
                end
            end
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
        isJumped = 1'b0;
        stall = stall_force || (int'($urandom_range(99, 0)) < stall_pct);
    endtask

    // Expected stream of a path: consecutive words from tgt up to the HALT word.
    task automatic start_path(input logic [31:0] tgt, input int len);
        halt_addr = tgt + 32'(4 * len);
        sbq.delete();
        for (int i = 0; i < len; i++) begin
            logic [31:0] a;
            a = tgt + 32'(4 * i);
            sbq.push_back('{instr: mem_word(a), pc_id: a + 32'd4});
        end
    endtask

    task automatic jump(input logic [31:0] raw, input int len);
        isJumped = 1'b1;
        jumpAddr = raw;
        start_path(raw & 32'hFFFF_FFFC, len);
        step();
        check("jump_pc", imem_addr, raw & 32'hFFFF_FFFC);
        check("jump_unhalt", 32'(halted), 0);
    endtask

    task automatic run_to_halt(input int budget);
        int n;
        int sp;
        n = 0;
        while (!halted && n < budget) begin
            step();
            n++;
        end
        check("halt_reached", 32'(halted), 1);
        check("all_delivered", 32'(sbq.size()), 0);
        sp = stall_pct;
        stall_pct = 0;
        stall_force = 1'b0;
        repeat (3) step();
        check("halt_bubble", 32'(nop_if), 1);
        check("halt_no_req", 32'(imem_req), 0);
        check("halt_stays", 32'(halted), 1);
        stall_pct = sp;
    endtask

    task automatic wait_busy(input int budget);
        int n;
        n = 0;
        while (!mem_busy && n < budget) begin
            step();
            n++;
        end
        check("grant_seen", 32'(mem_busy), 1);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        stall = 1'b0;
        isJumped = 1'b0;
        jumpAddr = 32'd0;

        // Two-word program from reset with one-cycle memory.
        ovr[32'h0] = 32'h2001_0005;
        ovr[32'h4] = 32'h2002_0007;
        start_path(32'h0, 2);
        repeat (2) step();
        reset = 1'b1;
        run_to_halt(100);
        check("count_two", fetchCount, 2);
        ovr.delete();

        // Leave HALT through a redirect.
        step();
        jump(32'h100, 2);
        run_to_halt(100);

        // Response arrives under stall, held in the skid, released later.
        ovr[32'h200] = 32'h8C03_0000;
        step();
        stall_force = 1'b1;
        stall = 1'b1;
        jump(32'h200, 1);
        repeat (5) step();
        check("req_while_buffered", 32'(imem_req), 0);
        check("frozen_nop", 32'(nop_if), 1);
        stall_force = 1'b0;
        step();
        step();
        check("skid_release_nop", 32'(nop_if), 0);
        check("skid_release_instr", instr, 32'h8C03_0000);
        run_to_halt(100);
        ovr.delete();

        // Redirect while a granted response is still outstanding.
        lat_min = 4; lat_max = 4;
        step();
        jump(32'h10, 3);
        wait_busy(20);
        jump(32'h43, 2);
        lat_min = 1; lat_max = 2;
        run_to_halt(200);

        // Redirect in the same cycle as a response.
        step();
        jump(32'h300, 4);
        n = 0;
        while (!imem_valid && n < 50) begin
            step();
            n++;
        end
        check("valid_seen", 32'(imem_valid), 1);
        jump(32'h380, 2);
        run_to_halt(200);

        // PC wrap-around.
        step();
        jump(32'hFFFF_FFF9, 3);
        run_to_halt(200);

        // Reset while waiting on memory.
        lat_min = 4; lat_max = 4;
        step();
        jump(32'h500, 5);
        wait_busy(20);
        reset = 1'b0;
        start_path(32'h0, 3);
        step();
        reset = 1'b1;
        lat_min = 1; lat_max = 3;
        run_to_halt(200);
        check("count_after_reset", fetchCount, 3);

        // Random paths, latencies, grant rates and stalls; some cut short by a redirect.
        for (int e = 0; e < 30; e++) begin
            gnt_pct = 30 + int'($urandom % 71);
            lat_min = 1;
            lat_max = 1 + int'($urandom % 5);
            stall_pct = int'($urandom % 50);
            step();
            jump($urandom & 32'h0000_FFFF, 1 + int'($urandom % 6));
            if ($urandom % 3 == 0) begin
                repeat (2 + int'($urandom % 20)) step();
            end else begin
                run_to_halt(600);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
